// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

   localparam int LAT_CNT_W   = 4;
   localparam int MAX_LATENCY = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Single-port synchronous word array, DEPTH x DATA_W, contents never reset.
// Latency: write commits on the clock edge; read data registered, valid one cycle after the index.
// Backpressure: none, accepts an access every cycle.
module dmem_array #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1024
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_idx,
   input  logic [DATA_W-1:0]        i_wdata,
   output logic [DATA_W-1:0]        o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write-then-register read on the same index (read returns the pre-write word).
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
      r_rdata <= r_mem[i_idx];
   end

   assign o_rdata = r_rdata;

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// MEM-stage data-port responder: latches a request, waits LATENCY cycles, then performs it.
// Latency: ack/ldata LATENCY+1 cycles after the request is first seen; one access per LATENCY+2 cycles.
// Backpressure: combinational stall held high until the access completes (WRITE_BUF_EN posts writes).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2      // 1..MAX_LATENCY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              re_mem,
   input  logic              we_mem,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] sdata,
   output logic [DATA_W-1:0] ldata,
   output logic              stall,
   output logic              ack,
   output logic              err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [LAT_CNT_W-1:0] LAT_M1 = LAT_CNT_W'(LATENCY - 1);

   state_t               r_state, w_state_nxt;
   logic [LAT_CNT_W-1:0] r_cnt, w_cnt_nxt;
   op_t                  r_op;
   logic [IDX_W-1:0]     r_idx;
   logic [DATA_W-1:0]    r_wdata;
   logic [DATA_W-1:0]    r_ldata;
   logic                 r_ack;
   logic                 r_err;

   logic                 w_req;
   logic                 w_stall;
   logic                 w_accept;
   logic                 w_commit;
   logic                 w_wb_capture;
   logic                 w_arr_we;
   logic [IDX_W-1:0]     w_arr_idx;
   logic [DATA_W-1:0]    w_arr_wdata;
   logic [DATA_W-1:0]    w_rdata;
   logic                 w_unused;

   assign w_req    = re_mem | we_mem;
   // Upper address bits alias onto the same words by design.
   assign w_unused = ^addr;

`ifdef WRITE_BUF_EN
   logic                 r_wb_valid;
   logic [IDX_W-1:0]     r_wb_idx;
   logic [DATA_W-1:0]    r_wb_data;
   logic [LAT_CNT_W-1:0] r_wb_cnt;
   logic                 w_wb_commit;

   assign w_wb_commit = r_wb_valid && (r_wb_cnt == '0);
`endif

   // Next-state, stall and handshake decode; every request waits while a posted write drains.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_stall      = 1'b0;
      w_accept     = 1'b0;
      w_commit     = 1'b0;
      w_wb_capture = 1'b0;
      case (r_state)
         IDLE: begin
`ifdef WRITE_BUF_EN
            if (w_req) begin
               if (r_wb_valid) begin
                  w_stall = 1'b1;
               end else if (we_mem) begin
                  w_wb_capture = 1'b1;
               end else begin
                  w_accept    = 1'b1;
                  w_stall     = 1'b1;
                  w_state_nxt = BUSY;
                  w_cnt_nxt   = LAT_M1;
               end
            end
`else
            if (w_req) begin
               w_accept    = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = BUSY;
               w_cnt_nxt   = LAT_M1;
            end
`endif
         end
         BUSY: begin
            w_stall = 1'b1;
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - LAT_CNT_W'(1);
            end else begin
               w_commit    = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            // Inputs here are the just-completed request still on the bus.
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM state and wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Request capture so later input changes cannot disturb an access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op    <= OP_READ;
         r_idx   <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_op    <= we_mem ? OP_WRITE : OP_READ;
         r_idx   <= addr[IDX_W-1:0];
         r_wdata <= sdata;
      end
   end

   // Load data, completion pulse and sticky conflicting-request flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ldata <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_commit && (r_op == OP_READ)) begin
            r_ldata <= w_rdata;
         end
         r_ack <= w_commit | w_wb_capture;
         if (re_mem && we_mem && (w_accept || w_wb_capture)) begin
            r_err <= 1'b1;
         end
      end
   end

`ifdef WRITE_BUF_EN
   // Posted-write buffer: holds one write for LATENCY+1 cycles, then commits it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid <= 1'b0;
         r_wb_idx   <= '0;
         r_wb_data  <= '0;
         r_wb_cnt   <= '0;
      end else if (w_wb_capture) begin
         r_wb_valid <= 1'b1;
         r_wb_idx   <= addr[IDX_W-1:0];
         r_wb_data  <= sdata;
         r_wb_cnt   <= LAT_CNT_W'(LATENCY);
      end else if (r_wb_valid) begin
         if (r_wb_cnt == '0) begin
            r_wb_valid <= 1'b0;
         end else begin
            r_wb_cnt <= r_wb_cnt - LAT_CNT_W'(1);
         end
      end
   end

   // Array port steering: drain commit first, otherwise the live or latched request index.
   always_comb begin
      w_arr_we    = (w_commit && (r_op == OP_WRITE)) || w_wb_commit;
      w_arr_idx   = (r_state == IDLE) ? addr[IDX_W-1:0] : r_idx;
      w_arr_wdata = r_wdata;
      if (w_wb_commit) begin
         w_arr_idx   = r_wb_idx;
         w_arr_wdata = r_wb_data;
      end
   end
`else
   // Array port steering: live index in IDLE so read data is ready by the commit cycle.
   always_comb begin
      w_arr_we    = w_commit && (r_op == OP_WRITE);
      w_arr_idx   = (r_state == IDLE) ? addr[IDX_W-1:0] : r_idx;
      w_arr_wdata = r_wdata;
   end
`endif

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk     (clk),
      .i_we    (w_arr_we),
      .i_idx   (w_arr_idx),
      .i_wdata (w_arr_wdata),
      .o_rdata (w_rdata)
   );

   assign stall = rst_n & w_stall;
   assign ldata = r_ldata;
   assign ack   = r_ack;
   assign err   = r_err;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2, 1 and 15; posted-write case under WRITE_BUF_EN.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        re_i [3];
   logic        we_i [3];
   logic [15:0] ad_i [3];
   logic [15:0] sd_i [3];
   logic [15:0] ld_o [3];
   logic        st_o [3];
   logic        ak_o [3];
   logic        er_o [3];

   dmem_responder #(.LATENCY(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .re_mem(re_i[0]), .we_mem(we_i[0]), .addr(ad_i[0]),
      .sdata(sd_i[0]), .ldata(ld_o[0]), .stall(st_o[0]), .ack(ak_o[0]), .err(er_o[0]));
   dmem_responder #(.LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .re_mem(re_i[1]), .we_mem(we_i[1]), .addr(ad_i[1]),
      .sdata(sd_i[1]), .ldata(ld_o[1]), .stall(st_o[1]), .ack(ak_o[1]), .err(er_o[1]));
   dmem_responder #(.LATENCY(15)) u_dut_l15 (
      .clk(clk), .rst_n(rst_n), .re_mem(re_i[2]), .we_mem(we_i[2]), .addr(ad_i[2]),
      .sdata(sd_i[2]), .ldata(ld_o[2]), .stall(st_o[2]), .ack(ak_o[2]), .err(er_o[2]));

   typedef struct {
      logic        re;
      logic        we;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp_ld;
      logic        exp_err;
   } vec_t;

   vec_t tbl [8];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drives one request from just after a rising edge and follows it to its ack.
   task automatic do_txn(input int k, input int lat, input logic re, input logic we,
                         input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp_ld, input logic exp_err, input string nm);
      int stall_cnt;
      int ack_cyc;
      stall_cnt = 0;
      ack_cyc   = -1;
      re_i[k] = re; we_i[k] = we; ad_i[k] = a; sd_i[k] = d;
      for (int c = 0; c < lat + 8; c++) begin
         @(negedge clk);
         if (st_o[k] === 1'b1) stall_cnt++;
         if (ak_o[k] === 1'b1) begin
            ack_cyc = c;
            break;
         end
         next_cycle();
      end
      check({nm, " stall_width"}, stall_cnt, lat + 1);
      check({nm, " ack_cycle"}, ack_cyc, lat + 1);
      check({nm, " ldata"}, {16'h0, ld_o[k]}, {16'h0, exp_ld});
      check({nm, " err"}, {31'h0, er_o[k]}, {31'h0, exp_err});
      next_cycle();
      re_i[k] = 1'b0; we_i[k] = 1'b0;
      @(negedge clk);
      check({nm, " ack_pulse_end"}, {31'h0, ak_o[k]}, 32'h0);
      next_cycle();
   endtask

   initial begin
      logic [15:0] last_ld;
      for (int k = 0; k < 3; k++) begin
         re_i[k] = 1'b0; we_i[k] = 1'b0; ad_i[k] = '0; sd_i[k] = '0;
      end
      tbl[0] = '{1'b0, 1'b1, 16'h0020, 16'h0000, 16'h0000, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 16'h0011, 16'h1111, 16'hBEEF, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'h1111, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 16'h0410, 16'h7777, 16'h1111, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h7777, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0};

      // Reset with a request present: stall must stay low.
      rst_n   = 1'b0;
      re_i[0] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset stall", {31'h0, st_o[0]}, 32'h0);
      check("reset ack", {31'h0, ak_o[0]}, 32'h0);
      check("reset err", {31'h0, er_o[0]}, 32'h0);
      check("reset ldata", {16'h0, ld_o[0]}, 32'h0);
      re_i[0] = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

`ifdef WRITE_BUF_EN
      // Posted write followed immediately by a read of the same word.
      we_i[0] = 1'b1; ad_i[0] = 16'h0030; sd_i[0] = 16'hA5A5;
      @(negedge clk);
      check("wb write stall", {31'h0, st_o[0]}, 32'h0);
      next_cycle();
      we_i[0] = 1'b0; re_i[0] = 1'b1;
      @(negedge clk);
      check("wb write ack", {31'h0, ak_o[0]}, 32'h1);
      check("wb read stall c1", {31'h0, st_o[0]}, 32'h1);
      begin
         int stall_cnt;
         int ack_cyc;
         stall_cnt = 1;
         ack_cyc   = -1;
         for (int c = 2; c < 20; c++) begin
            next_cycle();
            @(negedge clk);
            if (st_o[0] === 1'b1) stall_cnt++;
            if (ak_o[0] === 1'b1) begin
               ack_cyc = c;
               break;
            end
         end
         check("wb read stall_width", stall_cnt, 6);
         check("wb read ack_cycle", ack_cyc, 7);
         check("wb read ldata", {16'h0, ld_o[0]}, 32'hA5A5);
      end
      next_cycle();
      re_i[0] = 1'b0;
      next_cycle();
`else
      for (int i = 0; i < 8; i++) begin
         do_txn(0, 2, tbl[i].re, tbl[i].we, tbl[i].a, tbl[i].d,
                tbl[i].exp_ld, tbl[i].exp_err, $sformatf("vec%0d", i));
      end

      // ldata holds after a read while the port is idle.
      do_txn(0, 2, 1'b1, 1'b0, 16'h0011, 16'h0, 16'h1111, 1'b0, "hold read");
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("ldata hold", {16'h0, ld_o[0]}, 32'h1111);
      next_cycle();

      // Request inputs change during BUSY: the latched read completes unchanged.
      re_i[0] = 1'b1; we_i[0] = 1'b0; ad_i[0] = 16'h0011; sd_i[0] = 16'h0;
      next_cycle();
      re_i[0] = 1'b0; we_i[0] = 1'b1; ad_i[0] = 16'h0010; sd_i[0] = 16'hDEAD;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("busy change ack", {31'h0, ak_o[0]}, 32'h1);
      check("busy change ldata", {16'h0, ld_o[0]}, 32'h1111);
      next_cycle();
      we_i[0] = 1'b0;
      next_cycle();
      do_txn(0, 2, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h7777, 1'b0, "no stray write");

      // Conflicting request executes as a write and sets the sticky flag.
      do_txn(0, 2, 1'b1, 1'b1, 16'h0004, 16'h1234, 16'h7777, 1'b1, "re_we");
      do_txn(0, 2, 1'b1, 1'b0, 16'h0004, 16'h0, 16'h1234, 1'b1, "re_we readback");

      // Reset during a write aborts it.
      we_i[0] = 1'b1; ad_i[0] = 16'h0020; sd_i[0] = 16'h5555;
      next_cycle();
      rst_n = 1'b0;
      #1;
      check("abort stall", {31'h0, st_o[0]}, 32'h0);
      check("abort ldata", {16'h0, ld_o[0]}, 32'h0);
      check("abort err", {31'h0, er_o[0]}, 32'h0);
      we_i[0] = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      do_txn(0, 2, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h0000, 1'b0, "abort readback");

      // Latency extremes: write then read back a small sweep.
      for (int k = 1; k < 3; k++) begin
         int lat;
         lat     = (k == 1) ? 1 : 15;
         last_ld = 16'h0000;
         for (int i = 0; i < 3; i++) begin
            do_txn(k, lat, 1'b0, 1'b1, 16'(i + 1), 16'(16'hC0 + i + 16 * k), last_ld, 1'b0,
                   $sformatf("lat%0d wr%0d", lat, i));
         end
         for (int i = 0; i < 3; i++) begin
            last_ld = 16'(16'hC0 + i + 16 * k);
            do_txn(k, lat, 1'b1, 1'b0, 16'(i + 1), 16'h0, last_ld, 1'b0,
                   $sformatf("lat%0d rd%0d", lat, i));
         end
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_dmem_responder
